acl_txsched: RTL and testbench

Master-side ACL transmit scheduler. On every master TX slot it chooses the LT_ADDR to address and the packet type to send: a retransmission, a POLL for a link whose poll interval has elapsed, new data, or a keep-alive POLL. Its outputs drive the TX packet encoder and the ARQ/flow-control logic, so SEQN and ARQN bookkeeping is applied to the chosen link.

---
 rtl/btbd_pkg.sv | 26 ++
 rtl/rr_pick7.sv | 27 ++
 rtl/acl_txsched.sv | 135 +++++++++++++
 tb/tb_acl_txsched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btbd_pkg.sv
// Shared baseband definitions: packet type codes, scheduler FSM states, LT_ADDR space.
package btbd_pkg;

  localparam int NLT = 8;

  localparam logic [3:0] PKT_NULL = 4'h0;
  localparam logic [3:0] PKT_POLL = 4'h1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

  // Lowest requesting link number (bit j stands for LT_ADDR j+1), 0 when none.
  function automatic logic [2:0] first_link(input logic [6:0] req);
    logic [2:0] r;
    r = 3'd0;
    for (int j = 6; j >= 0; j--) begin
      if (req[j]) r = 3'(j + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick7.sv
// Combinational round-robin picker over LT_ADDR 1..7, starting the search just after ptr.
module rr_pick7
  import btbd_pkg::*;
(
  input  logic [6:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] winner,
  output logic       valid
);

  logic [6:0] above;
  logic [6:0] hi;

  // Links numbered above ptr get first chance; otherwise wrap to the lowest requester.
  always_comb begin
    // NOTE: every bit gets a value before the loop, so no latch is inferred.
    above = '0;
    for (int j = 0; j < 7; j++) begin
      above[j] = (3'(j + 1) > ptr);
    end
  end

  assign hi     = req & above;
  assign winner = (|hi) ? first_link(hi) : first_link(req);
  assign valid  = |req;

endmodule

// File: rtl/acl_txsched.sv
// Master-side ACL TX scheduler: picks LT_ADDR and packet type for each master TX slot.
// Optional forced-poll class and poll counters are built when ACL_TXSCHED_TPOLL_EN is defined.
module acl_txsched
  import btbd_pkg::*;
#(
  parameter int NLT = btbd_pkg::NLT
) (
  input  logic           clk_6M,
  input  logic           rstz,
  input  logic           sched_en,
  input  logic           m_tslot_p,
  input  logic           ms_RXslot_endp,
  input  logic           reserved_p,
  input  logic [NLT-1:0] link_active,
  input  logic [NLT-1:0] txdatready,
  input  logic [NLT-1:0] dec_flow,
  input  logic [NLT-1:0] dec_arqn,
  input  logic [3:0]     regi_packet_type,
  input  logic [7:0]     regi_tpoll,
  output logic [2:0]     txpk_lt_addr,
  output logic [3:0]     txpktype,
  output logic           ms_txcmd_p,
  output logic [NLT-1:0] poll_due,
  output logic           sched_busy
);

  sched_state_t state;
  logic [2:0]   ptr;

  logic [7:1] l_mask, retx, newd;
  logic [2:0] retx_win, newd_win, ka_win, win;
  logic       retx_v, newd_v, ka_v, win_v, issue;
  logic [3:0] win_type;

  assign l_mask = link_active[7:1];
  assign retx   = l_mask & ~dec_arqn[7:1] & dec_flow[7:1];
  assign newd   = l_mask & txdatready[7:1] & dec_flow[7:1] & dec_arqn[7:1];

  rr_pick7 u_pick_retx (.req(retx),   .ptr(ptr), .winner(retx_win), .valid(retx_v));
  rr_pick7 u_pick_newd (.req(newd),   .ptr(ptr), .winner(newd_win), .valid(newd_v));
  rr_pick7 u_pick_ka   (.req(l_mask), .ptr(ptr), .winner(ka_win),   .valid(ka_v));

`ifdef ACL_TXSCHED_TPOLL_EN
  logic [7:1] pd;
  logic [2:0] pd_win;
  logic       pd_v;
  logic [7:0] pc [7:1];
  logic       unused_bits;

  assign pd = l_mask & poll_due[7:1];
  rr_pick7 u_pick_pd (.req(pd), .ptr(ptr), .winner(pd_win), .valid(pd_v));
  assign unused_bits = ^{link_active[0], txdatready[0], dec_flow[0], dec_arqn[0]};
`else
  logic unused_bits;
  assign unused_bits = ^{regi_tpoll, link_active[0], txdatready[0], dec_flow[0], dec_arqn[0]};
  assign poll_due    = '0;
`endif

  // Class priority: retransmission, overdue poll, new data, keep-alive poll.
  always_comb begin
    win      = 3'd0;
    win_type = PKT_NULL;
    win_v    = 1'b0;
    if (retx_v) begin
      win = retx_win; win_type = regi_packet_type; win_v = 1'b1;
    end
`ifdef ACL_TXSCHED_TPOLL_EN
    else if (pd_v) begin
      win = pd_win; win_type = PKT_POLL; win_v = 1'b1;
    end
`endif
    else if (newd_v) begin
      win = newd_win; win_type = regi_packet_type; win_v = 1'b1;
    end
    else if (ka_v) begin
      win = ka_win; win_type = PKT_POLL; win_v = 1'b1;
    end
  end

  assign issue      = (state == EVAL) && sched_en && win_v;
  assign sched_busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state        <= IDLE;
      ptr          <= 3'd7;
      txpk_lt_addr <= 3'd0;
      txpktype     <= PKT_NULL;
      ms_txcmd_p   <= 1'b0;
    end else begin
      ms_txcmd_p <= 1'b0;
      if (!sched_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (m_tslot_p && !reserved_p) state <= EVAL;
          EVAL: begin
            state        <= ISSUE;
            txpk_lt_addr <= win;
            txpktype     <= win_type;
            ms_txcmd_p   <= win_v;
            if (win_v) ptr <= win;
          end
          ISSUE:   state <= WAIT;
          WAIT:    if (ms_RXslot_endp) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ACL_TXSCHED_TPOLL_EN
  // NOTE: the seven counters are ordinary flops, not a RAM, so they take the async reset.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int i = 1; i <= 7; i++) pc[i] <= 8'd0;
    end else begin
      for (int i = 1; i <= 7; i++) begin
        if (!l_mask[i] || (issue && win == 3'(i))) pc[i] <= 8'd0;
        else if (m_tslot_p && pc[i] != 8'hFF)      pc[i] <= pc[i] + 8'd1;
      end
    end
  end

  always_comb begin
    poll_due = '0;
    for (int i = 1; i <= 7; i++) begin
      poll_due[i] = (regi_tpoll != 8'd0) && (pc[i] >= regi_tpoll);
    end
  end
`endif

endmodule

// File: tb/tb_acl_txsched.sv
// Scoreboard bench for acl_txsched with a slot-level reference model; honours ACL_TXSCHED_TPOLL_EN.
module tb_acl_txsched;
  import btbd_pkg::*;

  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic       sched_en = 1'b0, m_tslot_p = 1'b0, ms_RXslot_endp = 1'b0, reserved_p = 1'b0;
  logic [7:0] link_active = '0, txdatready = '0, dec_flow = '0, dec_arqn = '0, regi_tpoll = '0;
  logic [3:0] regi_packet_type = '0;
  logic [2:0] txpk_lt_addr;
  logic [3:0] txpktype;
  logic       ms_txcmd_p;
  logic [7:0] poll_due;
  logic       sched_busy;

  acl_txsched #(.NLT(8)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .sched_en(sched_en), .m_tslot_p(m_tslot_p),
    .ms_RXslot_endp(ms_RXslot_endp), .reserved_p(reserved_p), .link_active(link_active),
    .txdatready(txdatready), .dec_flow(dec_flow), .dec_arqn(dec_arqn),
    .regi_packet_type(regi_packet_type), .regi_tpoll(regi_tpoll),
    .txpk_lt_addr(txpk_lt_addr), .txpktype(txpktype), .ms_txcmd_p(ms_txcmd_p),
    .poll_due(poll_due), .sched_busy(sched_busy)
  );

  always #5 clk_6M = ~clk_6M;

  int cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int ptype;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: round-robin pointer, poll counters, last registered outputs.
  int m_ptr = 7;
  int m_pc[8];
  int m_last_addr = 0;
  int m_last_type = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int rr(input logic [7:0] req, input int p);
    int idx;
    for (int k = 1; k <= 7; k++) begin
      idx = ((p - 1 + k) % 7) + 1;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [7:0] exp_poll_due();
    logic [7:0] r;
    r = '0;
`ifdef ACL_TXSCHED_TPOLL_EN
    for (int i = 1; i <= 7; i++) r[i] = (regi_tpoll != 0) && (m_pc[i] >= int'(regi_tpoll));
`endif
    return r;
  endfunction

  // One slot pulse: counters advance; if the FSM starts, pick the winner and queue the command.
  task automatic model_slot(input bit go, input int p);
    logic [7:0] l, retx, newd, pd;
    int w, ty;
    l = link_active & 8'hFE;
    for (int i = 1; i <= 7; i++) if (l[i]) m_pc[i] = (m_pc[i] < 255) ? m_pc[i] + 1 : 255;
    if (!go) return;
    retx = l & ~dec_arqn & dec_flow;
    newd = l & txdatready & dec_flow & dec_arqn;
    pd   = exp_poll_due() & l;
    w = rr(retx, m_ptr); ty = int'(regi_packet_type);
    if (w == 0) begin w = rr(pd, m_ptr);   ty = int'(PKT_POLL); end
    if (w == 0) begin w = rr(newd, m_ptr); ty = int'(regi_packet_type); end
    if (w == 0) begin w = rr(l, m_ptr);    ty = int'(PKT_POLL); end
    if (w == 0) begin
      m_last_addr = 0; m_last_type = int'(PKT_NULL);
    end else begin
      sb.push_back('{p + 1, w, ty});
      m_ptr = w; m_pc[w] = 0;
      m_last_addr = w; m_last_type = ty;
    end
  endtask

  task automatic set_links(input logic [7:0] v);
    @(negedge clk_6M);
    link_active = v;
    for (int i = 1; i <= 7; i++) if (!v[i]) m_pc[i] = 0;
  endtask

  task automatic do_slot(input bit rsv, input bit drop_en, input bit extra);
    int p;
    bit go;
    @(negedge clk_6M);
    m_tslot_p = 1'b1; reserved_p = rsv;
    @(posedge clk_6M); #1;
    p = cyc; m_tslot_p = 1'b0; reserved_p = 1'b0;
    go = sched_en && !rsv;
    model_slot(go, p);
    @(negedge clk_6M);
    check("busy_at_eval", int'(sched_busy), int'(go));
    repeat (2) @(negedge clk_6M);
    if (extra && go) begin
      m_tslot_p = 1'b1;
      @(posedge clk_6M); #1;
      m_tslot_p = 1'b0;
      model_slot(1'b0, 0);
      @(negedge clk_6M);
    end
    if (drop_en && go) begin
      sched_en = 1'b0;
      @(negedge clk_6M);
      check("busy_after_en_drop", int'(sched_busy), 0);
      sched_en = 1'b1;
    end else begin
      ms_RXslot_endp = 1'b1;
      @(negedge clk_6M);
      ms_RXslot_endp = 1'b0;
      check("busy_after_endp", int'(sched_busy), 0);
    end
    check("lt_addr_hold", int'(txpk_lt_addr), m_last_addr);
    check("pktype_hold", int'(txpktype), m_last_type);
    check("poll_due", int'(poll_due), int'(exp_poll_due()));
  endtask

  // Monitor: every command pulse must match the oldest queued expectation.
  always @(negedge clk_6M) begin
    if (rstz && ms_txcmd_p) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: pulse to lt_addr %0d type %0d, expected none (cycle %0d)",
                 txpk_lt_addr, txpktype, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("cmd_cycle", cyc, mon_e.cyc);
        check("cmd_lt_addr", int'(txpk_lt_addr), mon_e.addr);
        check("cmd_pktype", int'(txpktype), mon_e.ptype);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) m_pc[i] = 0;
    repeat (3) @(negedge clk_6M);
    check("reset_lt_addr", int'(txpk_lt_addr), 0);
    check("reset_pktype", int'(txpktype), 0);
    check("reset_cmd", int'(ms_txcmd_p), 0);
    check("reset_busy", int'(sched_busy), 0);
    check("reset_poll_due", int'(poll_due), 0);
    rstz = 1'b1;
    @(negedge clk_6M);
    check("post_reset_busy", int'(sched_busy), 0);

    // Single link with data.
    set_links(8'h06);
    txdatready = 8'h04; dec_flow = 8'hFF; dec_arqn = 8'hFF;
    regi_packet_type = 4'h3; sched_en = 1'b1;
    do_slot(0, 0, 0);

    // Retransmission outranks new data.
    set_links(8'h0C);
    dec_arqn = 8'hF7; txdatready = 8'h04; regi_packet_type = 4'h4;
    do_slot(0, 0, 0);
    dec_arqn = 8'hFF;
    do_slot(0, 0, 0);

    // Round-robin wrap across links 1..3.
    set_links(8'h0E);
    txdatready = 8'h0E;
    repeat (4) do_slot(0, 0, 0);

    // Poll interval on an idle link.
    set_links(8'h22);
    txdatready = 8'h02; regi_tpoll = 8'd4;
    repeat (5) do_slot(0, 0, 0);

    // Reserved slots still age the counters; enable drop and ignored pulse in WAIT.
    set_links(8'h12);
    txdatready = 8'h02; regi_tpoll = 8'd3;
    do_slot(1, 0, 0);
    do_slot(1, 0, 0);
    do_slot(0, 0, 0);
    do_slot(0, 1, 0);
    do_slot(0, 0, 1);

    // No active link: nothing issued.
    set_links(8'h00);
    regi_tpoll = 8'd0;
    repeat (2) do_slot(0, 0, 0);

    // Counter saturation: link 6 never served while polls are disabled.
    set_links(8'h42);
    txdatready = 8'h02;
    repeat (260) do_slot(0, 0, 0);
    @(negedge clk_6M);
    regi_tpoll = 8'd255;
    @(negedge clk_6M);
    check("pc_saturated", int'(poll_due), int'(exp_poll_due()));
    do_slot(0, 0, 0);
    regi_tpoll = 8'd0;

    // Randomized slots.
    for (int n = 0; n < 150; n++) begin
      set_links(8'($urandom_range(0, 255)));
      txdatready       = 8'($urandom);
      dec_flow         = 8'($urandom | $urandom);
      dec_arqn         = 8'($urandom | $urandom);
      regi_packet_type = 4'($urandom);
      regi_tpoll       = 8'($urandom_range(0, 4));
      sched_en         = ($urandom_range(0, 9) != 0);
      do_slot($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      sched_en = 1'b1;
    end

    // Asynchronous reset while waiting for the RX slot.
    set_links(8'h0E);
    txdatready = 8'h0E; dec_flow = 8'hFF; dec_arqn = 8'hFF; regi_tpoll = 8'd2;
    @(negedge clk_6M);
    m_tslot_p = 1'b1;
    @(posedge clk_6M); #1;
    m_tslot_p = 1'b0;
    model_slot(1'b1, cyc);
    repeat (3) @(negedge clk_6M);
    #2 rstz = 1'b0;
    #1;
    check("async_rst_lt_addr", int'(txpk_lt_addr), 0);
    check("async_rst_pktype", int'(txpktype), 0);
    check("async_rst_busy", int'(sched_busy), 0);
    check("async_rst_poll_due", int'(poll_due), 0);
    @(negedge clk_6M);
    rstz = 1'b1;
    m_ptr = 7; m_last_addr = 0; m_last_type = 0;
    for (int i = 0; i < 8; i++) m_pc[i] = 0;
    do_slot(0, 0, 0);
    do_slot(0, 0, 0);

    repeat (4) @(negedge clk_6M);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
